// File: rtl/alu_operand_loader.sv
// alu_operand_loader: collects two 4-bit operands and a 3-bit opcode from the
// board switches, one value per debounced load-button press, and presents them
// to an ALU as a complete operand set until downstream takes it.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   sw         board switches (operand/opcode source)
//   btn_load   raw asynchronous load push-button
//   btn_clear  raw asynchronous clear push-button
//   out_ready  downstream has taken the current operand set
//   a, b       operands to the ALU (registered)
//   sel        opcode to the ALU (registered)
//   op_valid   a/b/sel form a complete operand set (registered)
//   state      current FSM state for LEDs (registered)
module alu_operand_loader #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] sw,
  input  logic       btn_load,
  input  logic       btn_clear,
  input  logic       out_ready,
  output logic [3:0] a,
  output logic [3:0] b,
  output logic [2:0] sel,
  output logic       op_valid,
  output logic [1:0] state
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_A     = 2'b00,
    S_B     = 2'b01,
    S_OP    = 2'b10,
    S_VALID = 2'b11
  } state_t;

  // Bit 0 is the load button, bit 1 the clear button.
  logic [1:0]    raw;
  logic [1:0]    sync1;
  logic [1:0]    sync2;
  logic [1:0]    deb;
  logic [1:0]    deb_q;
  logic [1:0]    press;
  logic [CW-1:0] cnt [2];

  assign raw = {btn_clear, btn_load};

  // Synchronizers, debouncers and registered press pulses for both buttons.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1  <= '0;
      sync2  <= '0;
      deb    <= '0;
      deb_q  <= '0;
      press  <= '0;
      cnt[0] <= '0;
      cnt[1] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      deb_q <= deb;
      // Pulse lands the cycle after the debounced level rises; falls give nothing.
      press <= deb & ~deb_q;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_MAX) begin
          deb[i] <= sync2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  state_t     st_q;
  state_t     st_n;
  logic [3:0] a_n;
  logic [3:0] b_n;
  logic [2:0] sel_n;

  // State and operand registers; op_valid tracks the next state so it is a flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q     <= S_A;
      a        <= '0;
      b        <= '0;
      sel      <= '0;
      op_valid <= 1'b0;
    end else begin
      st_q     <= st_n;
      a        <= a_n;
      b        <= b_n;
      sel      <= sel_n;
      op_valid <= (st_n == S_VALID);
    end
  end

  // Next state and operand capture; clear outranks load and out_ready.
  always_comb begin
    st_n  = st_q;
    a_n   = a;
    b_n   = b;
    sel_n = sel;
    if (press[1]) begin
      st_n  = S_A;
      a_n   = '0;
      b_n   = '0;
      sel_n = '0;
    end else begin
      case (st_q)
        S_A: begin
          if (press[0]) begin
            a_n  = sw;
            st_n = S_B;
          end
        end
        S_B: begin
          if (press[0]) begin
            b_n  = sw;
            st_n = S_OP;
          end
        end
        S_OP: begin
          if (press[0]) begin
            sel_n = sw[2:0];
            st_n  = S_VALID;
          end
        end
        S_VALID: begin
          // Load presses here are dropped, not queued.
          if (out_ready) begin
            st_n = S_A;
          end
        end
        default: st_n = S_A;
      endcase
    end
  end

  assign state = st_q;

endmodule

// File: tb/tb_alu_operand_loader.sv
// Bench for alu_operand_loader with DEBOUNCE_CYCLES=4: a cycle-stepped model
// of the button timing and operand collection is checked against the DUT
// every cycle, plus directed scenarios with literal expected values.
module tb_alu_operand_loader;

  localparam int unsigned DB = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] sw;
  logic       btn_load;
  logic       btn_clear;
  logic       out_ready;
  logic [3:0] a;
  logic [3:0] b;
  logic [2:0] sel;
  logic       op_valid;
  logic [1:0] state;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  alu_operand_loader #(.DEBOUNCE_CYCLES(DB)) dut (
    .clk       (clk),
    .rst       (rst),
    .sw        (sw),
    .btn_load  (btn_load),
    .btn_clear (btn_clear),
    .out_ready (out_ready),
    .a         (a),
    .b         (b),
    .sel       (sel),
    .op_valid  (op_valid),
    .state     (state)
  );

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a button press takes effect DB consecutive differing synchronized
  // samples after the 2-cycle synchronizer, plus one cycle of pulse, and the
  // operand set is filled A -> B -> opcode -> valid.
  logic [3:0] m_a;
  logic [3:0] m_b;
  logic [2:0] m_sel;
  int         m_st;
  bit   [1:0] m_s1;
  bit   [1:0] m_s2;
  bit   [1:0] m_deb;
  int         m_streak [2];
  longint     act_at [2];
  longint     cyc = 0;
  bit         clr_p;
  bit         ld_p;

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      m_a = '0; m_b = '0; m_sel = '0; m_st = 0;
      m_s1 = '0; m_s2 = '0; m_deb = '0;
      for (int i = 0; i < 2; i++) begin
        m_streak[i] = 0;
        act_at[i] = -1;
      end
    end else begin
      clr_p = (act_at[1] == cyc);
      ld_p  = (act_at[0] == cyc);
      if (clr_p) begin
        m_a = '0; m_b = '0; m_sel = '0; m_st = 0;
      end else if (m_st == 3) begin
        if (out_ready) m_st = 0;
      end else if (ld_p) begin
        if (m_st == 0) m_a = sw;
        else if (m_st == 1) m_b = sw;
        else m_sel = sw[2:0];
        m_st = m_st + 1;
      end
      for (int i = 0; i < 2; i++) begin
        if (m_s2[i] != m_deb[i]) begin
          m_streak[i]++;
          if (m_streak[i] == DB) begin
            m_deb[i] = m_s2[i];
            m_streak[i] = 0;
            if (m_deb[i]) act_at[i] = cyc + 2;
          end
        end else begin
          m_streak[i] = 0;
        end
      end
      m_s2 = m_s1;
      m_s1 = {btn_clear, btn_load};
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_a", 8'(a), 8'(m_a));
      check("model_b", 8'(b), 8'(m_b));
      check("model_sel", 8'(sel), 8'(m_sel));
      check("model_state", 8'(state), 8'(m_st));
      check("model_op_valid", 8'(op_valid), 8'(m_st == 3));
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input bit clr, input bit ld, input logic [3:0] v);
    sw = v;
    btn_clear = clr;
    btn_load = ld;
    step(10);
    btn_clear = 1'b0;
    btn_load = 1'b0;
    step(10);
  endtask

  task automatic expect_all(input string name, input logic [3:0] ea, input logic [3:0] eb,
                            input logic [2:0] es, input logic [1:0] est);
    check({name, "_a"}, 8'(a), 8'(ea));
    check({name, "_b"}, 8'(b), 8'(eb));
    check({name, "_sel"}, 8'(sel), 8'(es));
    check({name, "_state"}, 8'(state), 8'(est));
    check({name, "_op_valid"}, 8'(op_valid), 8'(est == 2'b11));
  endtask

  initial begin
    rst = 1'b1; sw = '0; btn_load = 1'b0; btn_clear = 1'b0; out_ready = 1'b0;
    step(3);
    chk_en = 1'b1;
    expect_all("reset", 4'h0, 4'h0, 3'd0, 2'd0);
    rst = 1'b0;

    // Latency: clean edge before edge 1, press acts at edge 8.
    sw = 4'd3;
    btn_load = 1'b1;
    step(7);
    check("latency_before", 8'(state), 8'd0);
    step(1);
    check("latency_edge", 8'(state), 8'd1);
    check("latency_a", 8'(a), 8'd3);
    step(5);
    check("single_pulse", 8'(state), 8'd1);
    btn_load = 1'b0;
    step(10);

    // Full load and hold while out_ready low.
    press(1'b0, 1'b1, 4'd5);
    press(1'b0, 1'b1, 4'b0001);
    expect_all("full_load", 4'd3, 4'd5, 3'b001, 2'd3);
    step(20);
    expect_all("valid_hold", 4'd3, 4'd5, 3'b001, 2'd3);
    out_ready = 1'b1;
    step(1);
    out_ready = 1'b0;
    expect_all("ready_taken", 4'd3, 4'd5, 3'b001, 2'd0);

    // Bounce rejection.
    sw = 4'd6;
    for (int i = 0; i < 10; i++) begin
      btn_load = ~btn_load;
      step(2);
    end
    btn_load = 1'b1;
    step(10);
    btn_load = 1'b0;
    step(10);
    check("bounce_state", 8'(state), 8'd1);
    check("bounce_a", 8'(a), 8'd6);

    // Clear mid-sequence, then simultaneous clear+load.
    press(1'b1, 1'b0, 4'd0);
    press(1'b0, 1'b1, 4'd9);
    press(1'b0, 1'b1, 4'd2);
    expect_all("in_s_op", 4'd9, 4'd2, 3'd0, 2'd2);
    press(1'b1, 1'b0, 4'd0);
    expect_all("clear", 4'd0, 4'd0, 3'd0, 2'd0);
    press(1'b0, 1'b1, 4'd9);
    press(1'b0, 1'b1, 4'd2);
    press(1'b1, 1'b1, 4'd7);
    expect_all("clear_and_load", 4'd0, 4'd0, 3'd0, 2'd0);

    // Ignored load in S_VALID; opcode 111 passes through.
    press(1'b0, 1'b1, 4'd1);
    press(1'b0, 1'b1, 4'd2);
    press(1'b0, 1'b1, 4'hF);
    expect_all("sel_passthru", 4'd1, 4'd2, 3'b111, 2'd3);
    sw = 4'hF;
    press(1'b0, 1'b1, 4'hA);
    expect_all("load_in_valid", 4'd1, 4'd2, 3'b111, 2'd3);
    out_ready = 1'b1;
    step(1);
    out_ready = 1'b0;
    step(10);
    expect_all("not_queued", 4'd1, 4'd2, 3'b111, 2'd0);

    // out_ready outside S_VALID.
    press(1'b0, 1'b1, 4'd4);
    out_ready = 1'b1;
    step(1);
    out_ready = 1'b0;
    step(2);
    expect_all("ready_in_s_b", 4'd4, 4'd2, 3'b111, 2'd1);

    // Reset in S_VALID with out_ready low.
    press(1'b0, 1'b1, 4'd5);
    press(1'b0, 1'b1, 4'd6);
    expect_all("pre_reset", 4'd4, 4'd5, 3'd6, 2'd3);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    expect_all("reset_in_valid", 4'd0, 4'd0, 3'd0, 2'd0);
    step(5);

    // Button held through reset release.
    sw = 4'd8;
    btn_load = 1'b1;
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    step(7);
    check("held_reset_before", 8'(state), 8'd0);
    step(1);
    check("held_reset_edge", 8'(state), 8'd1);
    check("held_reset_a", 8'(a), 8'd8);
    btn_load = 1'b0;
    step(10);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
